// File: rtl/lcd_bus_pkg.sv
// rtl/lcd_bus_pkg.sv - opcodes, decoder states and defaults for the 8080 bus receiver
package lcd_bus_pkg;

    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] SLPIN   = 8'h10;
    localparam logic [7:0] SLPOUT  = 8'h11;
    localparam logic [7:0] DISPOFF = 8'h28;
    localparam logic [7:0] DISPON  = 8'h29;
    localparam logic [7:0] CASET   = 8'h2A;
    localparam logic [7:0] PASET   = 8'h2B;
    localparam logic [7:0] RAMWR   = 8'h2C;
    localparam logic [7:0] COLMOD  = 8'h3A;

    localparam logic [7:0] COLMOD_DEFAULT = 8'h66;

    typedef enum logic [2:0] {
        IDLE,
        PARAM,
        IGNORE,
        PIX_HI,
        PIX_LO
    } rx_state_t;

endpackage

// File: rtl/lcd_bus_rx_if.sv
// rtl/lcd_bus_rx_if.sv - 8080-style write bus: data, rs, active-low wr, active-low panel reset
interface lcd_bus_rx_if;

    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_wr;
    logic       lcd_rst;

    modport master (output lcd_data, output lcd_rs, output lcd_wr, output lcd_rst);
    modport slave  (input lcd_data, input lcd_rs, input lcd_wr, input lcd_rst);

endinterface

// File: rtl/lcd_bus_rx_ptr.sv
// rtl/lcd_bus_rx_ptr.sv - address window registers and RAMWR pixel pointer with window wrap
module lcd_bus_rx_ptr import lcd_bus_pkg::*; #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        set_x,
    input  logic        set_y,
    input  logic [15:0] set_start,
    input  logic [15:0] set_end,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] win_xs,
    output logic [15:0] win_xe,
    output logic [15:0] win_ys,
    output logic [15:0] win_ye,
    output logic [15:0] ptr_x,
    output logic [15:0] ptr_y
);

    localparam logic [15:0] XE_DEFAULT = 16'(H_RES - 1);
    localparam logic [15:0] YE_DEFAULT = 16'(V_RES - 1);

    // window update on the last CASET/PASET byte; pointer load on RAMWR, advance per pixel
    always_ff @(posedge clk) begin
        if (clr) begin
            win_xs <= 16'd0;
            win_xe <= XE_DEFAULT;
            win_ys <= 16'd0;
            win_ye <= YE_DEFAULT;
            ptr_x  <= 16'd0;
            ptr_y  <= 16'd0;
        end else begin
            if (set_x) begin
                win_xs <= set_start;
                win_xe <= set_end;
            end
            if (set_y) begin
                win_ys <= set_start;
                win_ye <= set_end;
            end
            if (load) begin
                ptr_x <= win_xs;
                ptr_y <= win_ys;
            end else if (advance) begin
                if (ptr_x >= win_xe) begin
                    ptr_x <= win_xs;
                    ptr_y <= (ptr_y >= win_ye) ? win_ys : ptr_y + 16'd1;
                end else begin
                    ptr_x <= ptr_x + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_bus_rx.sv
// rtl/lcd_bus_rx.sv - 8080 bus write decoder; optional sticky err output under LCD_BUS_RX_ERR_EN
module lcd_bus_rx import lcd_bus_pkg::*; #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        reset,
    lcd_bus_rx_if.slave bus,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic        param_valid,
    output logic [7:0]  param,
    output logic [3:0]  param_idx,
    output logic        pixel_valid,
    output logic [15:0] pixel,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    output logic [15:0] win_xs,
    output logic [15:0] win_xe,
    output logic [15:0] win_ys,
    output logic [15:0] win_ye,
    output logic [7:0]  colmod,
    output logic        sleep,
    output logic        display_on
`ifdef LCD_BUS_RX_ERR_EN
    ,
    output logic        err
`endif
);

    rx_state_t   state_q, state_d;
    logic        wr_q;
    logic        accept;
    logic        clr;
    logic [3:0]  pcnt_q;
    logic [7:0]  hi_q;
    logic [23:0] stage_q;
    logic        cmd_fire, param_fire, hi_fire, pix_fire;
    logic        soft_rst, load, win_last, set_x, set_y;
    logic [15:0] set_start, set_end;
    logic [15:0] ptr_x, ptr_y;

    assign accept    = bus.lcd_wr & ~wr_q;
    assign clr       = reset | ~bus.lcd_rst;
    assign soft_rst  = cmd_fire && (bus.lcd_data == SWRESET);
    assign load      = cmd_fire && (bus.lcd_data == RAMWR);
    assign win_last  = param_fire && (state_q == PARAM) && (pcnt_q == 4'd3);
    assign set_x     = win_last && (cmd == CASET);
    assign set_y     = win_last && (cmd == PASET);
    assign set_start = stage_q[23:8];
    assign set_end   = {stage_q[7:0], bus.lcd_data};

    // previous wr level for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) wr_q <= 1'b1;
        else       wr_q <= bus.lcd_wr;
    end

    // decoder state register
    always_ff @(posedge clk) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state and byte classification
    always_comb begin
        state_d    = state_q;
        cmd_fire   = 1'b0;
        param_fire = 1'b0;
        hi_fire    = 1'b0;
        pix_fire   = 1'b0;
        if (accept) begin
            if (!bus.lcd_rs) begin
                cmd_fire = 1'b1;
                case (bus.lcd_data)
                    SWRESET, SLPIN, SLPOUT, DISPOFF, DISPON: state_d = IDLE;
                    CASET, PASET, COLMOD:                    state_d = PARAM;
                    RAMWR:                                   state_d = PIX_HI;
                    default:                                 state_d = IGNORE;
                endcase
            end else begin
                case (state_q)
                    PARAM, IGNORE: param_fire = 1'b1;
                    PIX_HI: begin
                        hi_fire = 1'b1;
                        state_d = PIX_LO;
                    end
                    PIX_LO: begin
                        pix_fire = 1'b1;
                        state_d  = PIX_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    // registered outputs, display state and parameter staging
    always_ff @(posedge clk) begin
        if (clr) begin
            cmd_valid   <= 1'b0;
            cmd         <= 8'd0;
            param_valid <= 1'b0;
            param       <= 8'd0;
            param_idx   <= 4'd0;
            pcnt_q      <= 4'd0;
            pixel_valid <= 1'b0;
            pixel       <= 16'd0;
            pixel_x     <= 16'd0;
            pixel_y     <= 16'd0;
            colmod      <= COLMOD_DEFAULT;
            sleep       <= 1'b1;
            display_on  <= 1'b0;
            hi_q        <= 8'd0;
            stage_q     <= 24'd0;
        end else begin
            cmd_valid   <= cmd_fire;
            param_valid <= param_fire;
            pixel_valid <= pix_fire;
            if (cmd_fire) begin
                cmd       <= bus.lcd_data;
                param_idx <= 4'd0;
                pcnt_q    <= 4'd0;
                case (bus.lcd_data)
                    SWRESET: begin
                        colmod     <= COLMOD_DEFAULT;
                        sleep      <= 1'b1;
                        display_on <= 1'b0;
                    end
                    SLPIN:   sleep      <= 1'b1;
                    SLPOUT:  sleep      <= 1'b0;
                    DISPON:  display_on <= 1'b1;
                    DISPOFF: display_on <= 1'b0;
                    default: ;
                endcase
            end
            if (param_fire) begin
                param     <= bus.lcd_data;
                param_idx <= pcnt_q;
                if (pcnt_q != 4'd15) pcnt_q <= pcnt_q + 4'd1;
                if (state_q == PARAM) begin
                    if (cmd == COLMOD && pcnt_q == 4'd0) colmod <= bus.lcd_data;
                    if (cmd == CASET || cmd == PASET) begin
                        case (pcnt_q)
                            4'd0:    stage_q[23:16] <= bus.lcd_data;
                            4'd1:    stage_q[15:8]  <= bus.lcd_data;
                            4'd2:    stage_q[7:0]   <= bus.lcd_data;
                            default: ;
                        endcase
                    end
                end
            end
            if (hi_fire) hi_q <= bus.lcd_data;
            if (pix_fire) begin
                pixel   <= {hi_q, bus.lcd_data};
                pixel_x <= ptr_x;
                pixel_y <= ptr_y;
            end
        end
    end

    lcd_bus_rx_ptr #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_ptr (
        .clk       (clk),
        .clr       (clr | soft_rst),
        .set_x     (set_x),
        .set_y     (set_y),
        .set_start (set_start),
        .set_end   (set_end),
        .load      (load),
        .advance   (pix_fire),
        .win_xs    (win_xs),
        .win_xe    (win_xe),
        .win_ys    (win_ys),
        .win_ye    (win_ye),
        .ptr_x     (ptr_x),
        .ptr_y     (ptr_y)
    );

`ifdef LCD_BUS_RX_ERR_EN
    logic err_evt;

    // protocol violations seen this cycle
    always_comb begin
        err_evt = 1'b0;
        if (accept && bus.lcd_rs && state_q == IDLE) err_evt = 1'b1;
        if (param_fire && state_q == PARAM &&
            (((cmd == CASET || cmd == PASET) && pcnt_q >= 4'd4) ||
             (cmd == COLMOD && pcnt_q >= 4'd1)))
            err_evt = 1'b1;
        if (cmd_fire && state_q == PIX_LO) err_evt = 1'b1;
        if ((set_x || set_y) && set_start > set_end) err_evt = 1'b1;
    end

    // sticky error flag
    always_ff @(posedge clk) begin
        if (clr)          err <= 1'b0;
        else if (err_evt) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb/tb_lcd_bus_rx.sv - directed self-checking bench for lcd_bus_rx
module tb_lcd_bus_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, param_valid, pixel_valid, sleep, display_on;
    logic [7:0]  cmd, param, colmod;
    logic [3:0]  param_idx;
    logic [15:0] pixel, pixel_x, pixel_y, win_xs, win_xe, win_ys, win_ye;
`ifdef LCD_BUS_RX_ERR_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_cmd = 0;
    int n_param = 0;
    int n_pix = 0;
    int base;
    logic [15:0] pv[$];
    logic [15:0] pxq[$];
    logic [15:0] pyq[$];

    lcd_bus_rx_if bus ();

    lcd_bus_rx #(.H_RES(320), .V_RES(240)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .param_valid (param_valid),
        .param       (param),
        .param_idx   (param_idx),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .win_xs      (win_xs),
        .win_xe      (win_xe),
        .win_ys      (win_ys),
        .win_ye      (win_ye),
        .colmod      (colmod),
        .sleep       (sleep),
        .display_on  (display_on)
`ifdef LCD_BUS_RX_ERR_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) n_cmd++;
        if (param_valid === 1'b1) n_param++;
        if (pixel_valid === 1'b1) begin
            n_pix++;
            pv.push_back(pixel);
            pxq.push_back(pixel_x);
            pyq.push_back(pixel_y);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr_byte(input logic rs, input logic [7:0] d);
        @(negedge clk);
        bus.lcd_rs   = rs;
        bus.lcd_data = d;
        bus.lcd_wr   = 1'b0;
        @(negedge clk);
        bus.lcd_wr   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ex [7];
        logic [15:0] ey [7];
        ex = '{16'd10, 16'd11, 16'd12, 16'd10, 16'd11, 16'd12, 16'd10};
        ey = '{16'd5, 16'd5, 16'd5, 16'd6, 16'd6, 16'd6, 16'd5};

        bus.lcd_data = 8'h00;
        bus.lcd_rs   = 1'b0;
        bus.lcd_wr   = 1'b1;
        bus.lcd_rst  = 1'b1;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check("rst_sleep", 32'(sleep), 32'h1);
        check("rst_display_on", 32'(display_on), 32'h0);
        check("rst_colmod", 32'(colmod), 32'h66);
        check("rst_win_xe", 32'(win_xe), 32'd319);
        check("rst_win_ye", 32'(win_ye), 32'd239);
`ifdef LCD_BUS_RX_ERR_EN
        check("rst_err", 32'(err), 32'h0);
`endif

        base = n_cmd;
        wr_byte(1'b0, 8'h11);
        check("slpout_pulse", 32'(cmd_valid), 32'h1);
        check("slpout_cmd", 32'(cmd), 32'h11);
        check("slpout_sleep", 32'(sleep), 32'h0);
        @(posedge clk);
        #1;
        check("slpout_pulse_end", 32'(cmd_valid), 32'h0);
        wr_byte(1'b0, 8'h29);
        check("dispon_on", 32'(display_on), 32'h1);
        settle();
        check("cmd_pulses", 32'(n_cmd - base), 32'd2);
        check("def_win_xs", 32'(win_xs), 32'd0);
        check("def_win_ys", 32'(win_ys), 32'd0);

        wr_byte(1'b0, 8'h2A);
        wr_byte(1'b1, 8'h00);
        wr_byte(1'b1, 8'h0A);
        wr_byte(1'b1, 8'h00);
        check("caset_not_atomic_yet", 32'(win_xs), 32'd0);
        wr_byte(1'b1, 8'h0C);
        check("caset_pvalid", 32'(param_valid), 32'h1);
        check("caset_idx", 32'(param_idx), 32'd3);
        check("caset_param", 32'(param), 32'h0C);
        check("caset_xs", 32'(win_xs), 32'd10);
        check("caset_xe", 32'(win_xe), 32'd12);
        wr_byte(1'b0, 8'h2B);
        wr_byte(1'b1, 8'h00);
        wr_byte(1'b1, 8'h05);
        wr_byte(1'b1, 8'h00);
        wr_byte(1'b1, 8'h06);
        check("paset_ys", 32'(win_ys), 32'd5);
        check("paset_ye", 32'(win_ye), 32'd6);

        wr_byte(1'b0, 8'h2C);
        base = n_pix;
        for (int k = 0; k < 7; k++) begin
            wr_byte(1'b1, 8'h10 + 8'(k));
            wr_byte(1'b1, 8'h20 + 8'(k));
        end
        settle();
        check("win_pix_count", 32'(n_pix - base), 32'd7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("win_pix%0d_x", k), 32'(pxq[base + k]), 32'(ex[k]));
            check($sformatf("win_pix%0d_y", k), 32'(pyq[base + k]), 32'(ey[k]));
            check($sformatf("win_pix%0d_v", k), 32'(pv[base + k]), 32'({8'h10 + 8'(k), 8'h20 + 8'(k)}));
        end

        wr_byte(1'b0, 8'h01);
        check("swreset_pulse", 32'(cmd_valid), 32'h1);
        check("swreset_cmd", 32'(cmd), 32'h01);
        check("swreset_sleep", 32'(sleep), 32'h1);
        check("swreset_disp", 32'(display_on), 32'h0);
        check("swreset_xs", 32'(win_xs), 32'd0);
        check("swreset_xe", 32'(win_xe), 32'd319);
        check("swreset_ye", 32'(win_ye), 32'd239);

        wr_byte(1'b0, 8'h2C);
        base = n_pix;
        wr_byte(1'b1, 8'hF8);
        wr_byte(1'b1, 8'h00);
        wr_byte(1'b1, 8'h07);
        wr_byte(1'b1, 8'hE0);
        settle();
        check("rgb_count", 32'(n_pix - base), 32'd2);
        check("rgb0_v", 32'(pv[base]), 32'hF800);
        check("rgb0_xy", 32'({pxq[base], pyq[base]}), 32'h0000_0000);
        check("rgb1_v", 32'(pv[base + 1]), 32'h07E0);
        check("rgb1_xy", 32'({pxq[base + 1], pyq[base + 1]}), 32'h0001_0000);

        wr_byte(1'b0, 8'h29);
        wr_byte(1'b0, 8'h2C);
        base = n_pix;
        wr_byte(1'b1, 8'hAA);
`ifdef LCD_BUS_RX_ERR_EN
        check("err_before_abort", 32'(err), 32'h0);
`endif
        wr_byte(1'b0, 8'h28);
        check("dispoff", 32'(display_on), 32'h0);
        settle();
        check("abort_no_pixel", 32'(n_pix - base), 32'd0);
`ifdef LCD_BUS_RX_ERR_EN
        check("abort_err", 32'(err), 32'h1);
`endif

        wr_byte(1'b0, 8'h3A);
        wr_byte(1'b1, 8'h55);
        check("colmod_set", 32'(colmod), 32'h55);
        check("colmod_idx", 32'(param_idx), 32'd0);
        wr_byte(1'b1, 8'h77);
        check("colmod_extra_pvalid", 32'(param_valid), 32'h1);
        check("colmod_extra_idx", 32'(param_idx), 32'd1);
        check("colmod_extra_kept", 32'(colmod), 32'h55);
        wr_byte(1'b0, 8'hB1);
        wr_byte(1'b1, 8'h12);
        check("ignore_pvalid", 32'(param_valid), 32'h1);
        check("ignore_param", 32'(param), 32'h12);

        wr_byte(1'b0, 8'h2A);
        wr_byte(1'b1, 8'h00);
        wr_byte(1'b1, 8'h0A);
        @(negedge clk);
        bus.lcd_rst = 1'b0;
        @(posedge clk);
        #1;
        check("prst_cmd", 32'(cmd), 32'h0);
        check("prst_param", 32'(param), 32'h0);
        check("prst_colmod", 32'(colmod), 32'h66);
`ifdef LCD_BUS_RX_ERR_EN
        check("prst_err", 32'(err), 32'h0);
`endif
        wr_byte(1'b0, 8'h29);
        check("prst_ignored_disp", 32'(display_on), 32'h0);
        check("prst_ignored_cmd", 32'(cmd_valid), 32'h0);
        @(negedge clk);
        bus.lcd_rst = 1'b1;
        base = n_param;
        wr_byte(1'b1, 8'h00);
        wr_byte(1'b1, 8'h0C);
        settle();
        check("stray_dropped", 32'(n_param - base), 32'd0);
        check("stray_win_xs", 32'(win_xs), 32'd0);
        check("stray_win_xe", 32'(win_xe), 32'd319);
`ifdef LCD_BUS_RX_ERR_EN
        check("stray_err", 32'(err), 32'h1);
`endif

        wr_byte(1'b0, 8'h29);
        wr_byte(1'b0, 8'h2C);
        base = n_pix;
        for (int i = 0; i < 32; i++) wr_byte(1'b1, 8'(i));
        settle();
        check("stream_count", 32'(n_pix - base), 32'd16);
        check("stream_last_x", 32'(pxq[base + 15]), 32'd15);
        check("stream_last_v", 32'(pv[base + 15]), 32'h1E1F);
        wr_byte(1'b1, 8'hC3);
        wr_byte(1'b1, 8'h3C);
        check("pre_rst_pvalid", 32'(pixel_valid), 32'h1);
        check("pre_rst_pixel", 32'(pixel), 32'hC33C);
        check("pre_rst_x", 32'(pixel_x), 32'd16);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_pvalid", 32'(pixel_valid), 32'h0);
        check("mrst_pixel", 32'(pixel), 32'h0);
        check("mrst_x", 32'(pixel_x), 32'h0);
        check("mrst_cmd", 32'(cmd), 32'h0);
        check("mrst_disp", 32'(display_on), 32'h0);
        check("mrst_sleep", 32'(sleep), 32'h1);
        check("mrst_colmod", 32'(colmod), 32'h66);
        check("mrst_win_xe", 32'(win_xe), 32'd319);
`ifdef LCD_BUS_RX_ERR_EN
        check("mrst_err", 32'(err), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_rx.md
# lcd_bus_rx

Panel-side decoder for the 8-bit 8080-style write bus driven by the LCD initialisation and drawing logic (data, rs, active-low wr, active-low panel reset). Samples each write strobe, splits commands from parameters, and tracks display state, the CASET/PASET address window and the RAMWR pixel pointer. Emits decoded command, parameter and pixel events. Used as the in-design display model for simulation and as an on-chip bus monitor.

## Interface
- H_RES, 320: panel width; default column end = H_RES-1.
- V_RES, 240: panel height; default page end = V_RES-1.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- lcd_data  input  8  bus byte.
- lcd_rs  input  1  0 = command byte, 1 = parameter/data byte.
- lcd_wr  input  1  active-low write strobe; byte taken on its rising edge.
- lcd_rst  input  1  active-low panel reset.
- cmd_valid  output  1  one-cycle pulse: command byte decoded.
- cmd  output  8  last command byte; holds.
- param_valid  output  1  one-cycle pulse: parameter byte accepted (non-RAMWR).
- param  output  8  parameter byte; holds.
- param_idx  output  4  index of that parameter within its command, saturates at 15.
- pixel_valid  output  1  one-cycle pulse: RGB565 pixel complete.
- pixel  output  16  {high byte, low byte}.
- pixel_x, pixel_y  output  16 each  coordinate of the emitted pixel.
- win_xs, win_xe, win_ys, win_ye  output  16 each  active window.
- colmod  output  8  last COLMOD parameter.
- sleep  output  1  1 = sleep-in.
- display_on  output  1  1 = display on.

## Operation
- Strobe detect: wr_q <= lcd_wr. Byte accepted in cycle N when lcd_wr=1 and wr_q=0, using lcd_data/lcd_rs of cycle N. wr_q resets to 1.
- Priority per cycle: reset > lcd_rst=0 > accepted byte. While lcd_rst=0, bytes are ignored.
- Decoder reset state (reset, lcd_rst=0, or command 0x01 SWRESET): FSM IDLE, window = (0, H_RES-1, 0, V_RES-1), pointer = (0,0), colmod=0x66, sleep=1, display_on=0. All pulses 0; cmd/param/pixel/param_idx = 0 on reset and lcd_rst. SWRESET still pulses cmd_valid.
- Any rs=0 byte: pulses cmd_valid, clears param_idx, discards any pending pixel high byte, and moves FSM by opcode:
  - 0x11 SLPOUT: sleep=0.
  - 0x10 SLPIN: sleep=1.
  - 0x29 DISPON / 0x28 DISPOFF: display_on=1/0.
  - 0x2A CASET, 0x2B PASET, 0x3A COLMOD: to PARAM.
  - 0x2C RAMWR: pointer=(win_xs,win_ys); to PIX_HI.
  - Others: to IGNORE.
- PARAM (rs=1): pulse param_valid with param_idx. CASET/PASET: bytes 0..3 = start[15:8], start[7:0], end[15:8], end[7:0]; window updates atomically on byte 3. COLMOD: byte 0 -> colmod. Extra bytes are reported but not applied.
- IGNORE (rs=1): param_valid pulses; no state change.
- IDLE (rs=1): byte dropped, no pulse.
- PIX_HI: latch high byte -> PIX_LO. PIX_LO: pulse pixel_valid with current pointer, then advance: if x>=win_xe then x=win_xs and (y>=win_ye ? y=win_ys : y+1), else x+1 -> PIX_HI. Window wrap is continuous with no end-of-frame stop.

## Timing
- All outputs registered. A byte accepted in cycle N produces its pulse/state update in cycle N+1. Pulses last exactly one cycle.
- The minimum strobe period is 2 clk (low for 1, high for 1). Back-to-back bytes at that rate must all be decoded.
- The window written by CASET/PASET is visible on win_* in N+1. A RAMWR in the next accepted byte uses it.

## Configuration
- LCD_BUS_RX_ERR_EN defined: adds output err (1 bit, sticky, cleared only by reset/lcd_rst) set when any of these occur:
  - an rs=1 byte arrives in IDLE;
  - a CASET/PASET/COLMOD parameter exceeds its count;
  - a command arrives while a pixel high byte is pending;
  - a completed window has start > end.
- Not defined: no err port, no error logic; behaviour otherwise identical.

## Structure
- Package lcd_bus_pkg: opcode localparams (SWRESET, SLPIN, SLPOUT, DISPOFF, DISPON, CASET, PASET, RAMWR, COLMOD), FSM state enum (IDLE, PARAM, IGNORE, PIX_HI, PIX_LO), default colmod.
- Sub-module lcd_bus_rx_ptr: window registers plus pixel pointer advance and wrap.

## Test plan
- Reset, then SLPOUT, DISPON -> two cmd_valid pulses; sleep=0, display_on=1; window (0,319,0,239).
- CASET 00 0A 00 0C, PASET 00 05 00 06, RAMWR, 14 bytes -> 7 pixels at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6),(10,5) (wrap).
- RAMWR bytes F8 00 07 E0 -> pixel 0xF800 at (0,0), 0x07E0 at (1,0).
- RAMWR, single byte AA, then DISPOFF -> no pixel_valid; display_on=0; err=1 with LCD_BUS_RX_ERR_EN.
- lcd_rst low mid-CASET (2 bytes sent), release, then 2 bytes -> window unchanged at defaults; stray bytes dropped.
- Strobe at 2-clk period for 32 RAMWR bytes -> exactly 16 pixel_valid pulses; reset asserted mid-stream -> all outputs at reset values the next cycle.
